hockey_arena: RTL and testbench
===============================

# hockey_arena

Parametrised air-hockey game engine, successor to the fixed 5x5 `hockey` core. It runs serve, puck flight, wall bounce, receive window, goal scoring and match end on a configurable FIELD_X x FIELD_Y grid. Puck speed, response window, goal display time and winning score are all parameters. It sits between the debounced player inputs (buttons, direction switches, Y guess) and the display/score drivers.

## Interface
Parameters:
- FIELD_X, 5: columns; A's goal line is X=0, B's is X=FIELD_X-1; must be ≥2
- FIELD_Y, 5: rows, Y=0 bottom; must be ≥2
- COORD_W, 3: coordinate width; 2^COORD_W ≥ max(FIELD_X, FIELD_Y)
- STEP_CYCLES, 2: clock cycles per puck step; ≥1
- RESP_WINDOW, 4: cycles the receiver has to hit; ≥1
- GOAL_CYCLES, 3: cycles spent in GOAL; ≥1
- WIN_SCORE, 3: score that ends the match; 1..2^SCORE_W-1
- SCORE_W, 4: score counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- BTN_A, BTN_B  in  1  player buttons, single-cycle pulses
- DIR_A, DIR_B  in  2  shot direction: 00 straight, 01 up (+Y), 10 down (−Y), 11 straight
- Y_in_A, Y_in_B  in  COORD_W  player Y position/guess
- X_COORD, Y_COORD  out  COORD_W  puck position
- SCORE_A, SCORE_B  out  SCORE_W  scores
- GAME_STATE  out  4  0 IDLE, 1 SERVE_A, 2 SERVE_B, 3 MOVE_AB, 4 MOVE_BA, 5 RESP_A, 6 RESP_B, 7 GOAL, 8 END
- WINNER  out  2  00 none, 01 A, 10 B

## Operation
- Reset (async, any state): GAME_STATE=IDLE; X_COORD, Y_COORD, SCORE_A, SCORE_B and WINNER all 0; step, window and goal counters cleared.
- IDLE: BTN_A goes to SERVE_A and BTN_B goes to SERVE_B. If both are pressed in the same cycle, A serves.
- SERVE_A/SERVE_B: X_COORD is the server's goal column. Only the server's button is honoured.
  - On press: Y = min(Y_in, FIELD_Y-1); direction latched from the server's DIR; next state MOVE_AB (A serves) or MOVE_BA (B serves).
- MOVE_*: buttons are ignored. Every STEP_CYCLES cycles the puck takes one step:
  - X moves one column toward the receiver.
  - Y changes by the latched direction.
  - Bounce: an up step with Y=FIELD_Y-1 gives Y=FIELD_Y-2 and direction becomes down. A down step with Y=0 gives Y=1 and direction becomes up.
  - The step that lands X on the receiver's column also moves the state to RESP_A/RESP_B.
- RESP_A/RESP_B: the window counter runs for RESP_WINDOW cycles, starting with the entry cycle. Only the receiver's button is honoured.
  - Press with Y_in == Y_COORD is a hit. Direction is latched from the receiver's DIR, the state goes to MOVE back toward the other side, and X is unchanged until the next step.
  - Press with mismatched Y is an immediate miss. No press within the window is also a miss.
  - A miss gives the opposite player a point: the score increments on the transition into GOAL.
- GOAL: puck position is held for GOAL_CYCLES cycles. Then:
  - if the scorer's score == WIN_SCORE: go to END;
  - otherwise the player who conceded serves (SERVE_A/SERVE_B).
- END: WINNER = 01 or 10. Scores and position are frozen and all inputs are ignored until rst.

## Timing
- All outputs are registered. GAME_STATE changes on the edge that samples the triggering input.
- Serve press sampled at edge k: MOVE begins at k with X at the server's column. Steps occur at edges k+S, k+2S, … (S = STEP_CYCLES), so the receiver column is reached at edge k+(FIELD_X-1)·S.
- A return hit at edge h: the first return step is at h+S.
- Timeout: a RESP entered at edge r with no press reaches GOAL at edge r+RESP_WINDOW.
- GOAL entered at edge g: the next state is taken at edge g+GOAL_CYCLES.
- Step counter resets on every state change. No step occurs outside MOVE.

## Test plan
Defaults for all scenarios: FIELD 5x5, S=2, RESP_WINDOW=4, GOAL_CYCLES=3, WIN_SCORE=3.
- Reset and tie-break: rst pulse mid-MOVE -> all outputs 0, GAME_STATE=0 in the same cycle. BTN_A and BTN_B pressed together in IDLE -> GAME_STATE=1.
- Straight rally: A serves Y_in_A=2, DIR_A=00 -> X steps 0,1,2,3,4 every 2 cycles, Y=2, RESP_B at serve+8. BTN_B with Y_in_B=2, DIR_B=10 -> MOVE_BA with Y sequence 1,0,1,2 at X=3,2,1,0.
- Bounce: A serves Y=3, DIR=01 -> Y at X=0..4 is 3,4,3,2,1.
- Timeout: no press in RESP_B -> GOAL after 4 cycles, SCORE_A=1, then SERVE_B after 3 cycles.
- Wrong guess and clamp: in RESP_B with Y_COORD=1, Y_in_B=2 pressed -> GOAL next edge, SCORE_A increments. Separately, a serve with Y_in=7 -> Y_COORD=4.
- Match end: A scores 3 times -> END, WINNER=01, SCORE_A=3. Button presses are then ignored until rst.

Source files
------------

// File: rtl/hockey_arena.sv
// rtl/hockey_arena.sv - parametrised air-hockey game engine
module hockey_arena #(
  parameter int FIELD_X     = 5,
  parameter int FIELD_Y     = 5,
  parameter int COORD_W     = 3,
  parameter int STEP_CYCLES = 2,
  parameter int RESP_WINDOW = 4,
  parameter int GOAL_CYCLES = 3,
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               BTN_A,
  input  logic               BTN_B,
  input  logic [1:0]         DIR_A,
  input  logic [1:0]         DIR_B,
  input  logic [COORD_W-1:0] Y_in_A,
  input  logic [COORD_W-1:0] Y_in_B,
  output logic [COORD_W-1:0] X_COORD,
  output logic [COORD_W-1:0] Y_COORD,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic [3:0]         GAME_STATE,
  output logic [1:0]         WINNER
);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SERVE_A   = 4'd1,
    SERVE_B   = 4'd2,
    MOVE_AB   = 4'd3,
    MOVE_BA   = 4'd4,
    RESP_A    = 4'd5,
    RESP_B    = 4'd6,
    GOAL      = 4'd7,
    MATCH_END = 4'd8
  } state_t;

  localparam int STEP_W = $clog2(STEP_CYCLES) + 1;
  localparam int RESP_W = $clog2(RESP_WINDOW) + 1;
  localparam int GOAL_W = $clog2(GOAL_CYCLES) + 1;
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FIELD_X - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FIELD_Y - 1);
  localparam logic [STEP_W-1:0]  STEP_END = STEP_W'(STEP_CYCLES - 1);
  localparam logic [RESP_W-1:0]  RESP_END = RESP_W'(RESP_WINDOW - 1);
  localparam logic [GOAL_W-1:0]  GOAL_END = GOAL_W'(GOAL_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [1:0]         DIR_UP   = 2'b01;
  localparam logic [1:0]         DIR_DOWN = 2'b10;

  state_t             state;
  logic [STEP_W-1:0]  step_cnt;
  logic [RESP_W-1:0]  win_cnt;
  logic [GOAL_W-1:0]  goal_cnt;
  logic [1:0]         dir;
  logic               scorer_b;
  logic [COORD_W-1:0] y_next;
  logic [1:0]         dir_next;
  logic [COORD_W-1:0] y_serve_a;
  logic [COORD_W-1:0] y_serve_b;

  assign GAME_STATE = state;

  // Y after one step, reflecting off the top and bottom walls
  always_comb begin
    y_next   = Y_COORD;
    dir_next = dir;
    if (dir == DIR_UP) begin
      if (Y_COORD == Y_LAST) begin
        y_next   = Y_LAST - 1'b1;
        dir_next = DIR_DOWN;
      end else begin
        y_next = Y_COORD + 1'b1;
      end
    end else if (dir == DIR_DOWN) begin
      if (Y_COORD == '0) begin
        y_next   = COORD_W'(1);
        dir_next = DIR_UP;
      end else begin
        y_next = Y_COORD - 1'b1;
      end
    end
  end

  always_comb begin
    y_serve_a = (Y_in_A > Y_LAST) ? Y_LAST : Y_in_A;
    y_serve_b = (Y_in_B > Y_LAST) ? Y_LAST : Y_in_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      X_COORD  <= '0;
      Y_COORD  <= '0;
      SCORE_A  <= '0;
      SCORE_B  <= '0;
      WINNER   <= 2'b00;
      step_cnt <= '0;
      win_cnt  <= '0;
      goal_cnt <= '0;
      dir      <= 2'b00;
      scorer_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (BTN_A) begin
            state   <= SERVE_A;
            X_COORD <= '0;
          end else if (BTN_B) begin
            state   <= SERVE_B;
            X_COORD <= X_LAST;
          end
        end
        SERVE_A: begin
          if (BTN_A) begin
            Y_COORD  <= y_serve_a;
            dir      <= DIR_A;
            step_cnt <= '0;
            state    <= MOVE_AB;
          end
        end
        SERVE_B: begin
          if (BTN_B) begin
            Y_COORD  <= y_serve_b;
            dir      <= DIR_B;
            step_cnt <= '0;
            state    <= MOVE_BA;
          end
        end
        MOVE_AB, MOVE_BA: begin
          if (step_cnt == STEP_END) begin
            step_cnt <= '0;
            win_cnt  <= '0;
            Y_COORD  <= y_next;
            dir      <= dir_next;
            if (state == MOVE_AB) begin
              X_COORD <= X_COORD + 1'b1;
              if (X_COORD == X_LAST - 1'b1) state <= RESP_B;
            end else begin
              X_COORD <= X_COORD - 1'b1;
              if (X_COORD == COORD_W'(1)) state <= RESP_A;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        RESP_A: begin
          if (BTN_A && Y_in_A == Y_COORD) begin
            dir      <= DIR_A;
            step_cnt <= '0;
            state    <= MOVE_AB;
          end else if (BTN_A || win_cnt == RESP_END) begin
            SCORE_B  <= SCORE_B + 1'b1;
            scorer_b <= 1'b1;
            goal_cnt <= '0;
            state    <= GOAL;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        RESP_B: begin
          if (BTN_B && Y_in_B == Y_COORD) begin
            dir      <= DIR_B;
            step_cnt <= '0;
            state    <= MOVE_BA;
          end else if (BTN_B || win_cnt == RESP_END) begin
            SCORE_A  <= SCORE_A + 1'b1;
            scorer_b <= 1'b0;
            goal_cnt <= '0;
            state    <= GOAL;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        GOAL: begin
          // the player who conceded serves from their own goal column
          if (goal_cnt == GOAL_END) begin
            if (scorer_b) begin
              if (SCORE_B == WIN) begin
                state  <= MATCH_END;
                WINNER <= 2'b10;
              end else begin
                state   <= SERVE_A;
                X_COORD <= '0;
              end
            end else begin
              if (SCORE_A == WIN) begin
                state  <= MATCH_END;
                WINNER <= 2'b01;
              end else begin
                state   <= SERVE_B;
                X_COORD <= X_LAST;
              end
            end
          end else begin
            goal_cnt <= goal_cnt + 1'b1;
          end
        end
        MATCH_END: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hockey_arena.sv
// tb/tb_hockey_arena.sv - self-checking bench for hockey_arena
module tb_hockey_arena;
  localparam int FX = 5;
  localparam int FY = 5;
  localparam int CW = 3;
  localparam int S  = 2;
  localparam int RW = 4;
  localparam int GC = 3;
  localparam int WS = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_a, btn_b;
  logic [1:0]    dir_a, dir_b;
  logic [CW-1:0] y_a, y_b;
  logic [CW-1:0] x_coord, y_coord;
  logic [SW-1:0] score_a, score_b;
  logic [3:0]    game_state;
  logic [1:0]    winner;

  int checks = 0;
  int errors = 0;
  int m_sa, m_sb, server;
  bit over;

  typedef struct {
    int ba, bb, da, db, ya, yb, n;
    int st, x, y, sa, sb, w;
  } vec_t;
  vec_t tbl [28];

  hockey_arena #(
    .FIELD_X(FX), .FIELD_Y(FY), .COORD_W(CW), .STEP_CYCLES(S),
    .RESP_WINDOW(RW), .GOAL_CYCLES(GC), .WIN_SCORE(WS), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .BTN_A(btn_a), .BTN_B(btn_b),
    .DIR_A(dir_a), .DIR_B(dir_b), .Y_in_A(y_a), .Y_in_B(y_b),
    .X_COORD(x_coord), .Y_COORD(y_coord), .SCORE_A(score_a), .SCORE_B(score_b),
    .GAME_STATE(game_state), .WINNER(winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Y at column offset i of a leg, by unfolding the wall reflections
  function automatic int refl(input int y0, input int d, input int i);
    int p, per, m;
    per = 2 * (FY - 1);
    p = (d == 1) ? y0 + i : (d == 2) ? y0 - i : y0;
    m = ((p % per) + per) % per;
    return (m <= FY - 1) ? m : per - m;
  endfunction

  task automatic press(input int who, input int y, input int d);
    if (who == 0) begin
      btn_a = 1'b1; y_a = CW'(y); dir_a = 2'(d);
    end else begin
      btn_b = 1'b1; y_b = CW'(y); dir_b = 2'(d);
    end
    tick();
    btn_a = 1'b0;
    btn_b = 1'b0;
  endtask

  task automatic do_reset();
    btn_a = 1'b0; btn_b = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_sa = 0; m_sb = 0; over = 1'b0; server = 0;
  endtask

  task automatic start_match();
    int ba, bb;
    ba = $urandom_range(0, 1);
    bb = (ba != 0) ? $urandom_range(0, 1) : 1;
    btn_a = (ba != 0);
    btn_b = (bb != 0);
    tick();
    btn_a = 1'b0; btn_b = 1'b0;
    server = (ba != 0) ? 0 : 1;
    chk("start_state", game_state, server + 1);
    chk("start_x", x_coord, (server != 0) ? FX - 1 : 0);
  endtask

  // want: -1 random outcome, 0 A takes the point, 1 B takes the point
  task automatic play_point(input int want);
    int rcv, yin, d, y0, yexp, act, dl, legs;
    bit done;
    yin = $urandom_range(0, 7);
    d   = $urandom_range(0, 3);
    if (server == 0) begin
      dir_a = 2'(d); y_a = CW'(yin); btn_a = 1'b1; btn_b = ($urandom_range(0, 1) == 1);
    end else begin
      dir_b = 2'(d); y_b = CW'(yin); btn_b = 1'b1; btn_a = ($urandom_range(0, 1) == 1);
    end
    tick();
    btn_a = 1'b0; btn_b = 1'b0;
    y0  = (yin > FY - 1) ? FY - 1 : yin;
    rcv = 1 - server;
    chk("serve_state", game_state, (rcv != 0) ? 3 : 4);
    chk("serve_x", x_coord, (rcv != 0) ? 0 : FX - 1);
    chk("serve_y", y_coord, y0);
    legs = 0;
    done = 1'b0;
    while (!done) begin
      for (int i = 1; i < FX; i++) begin
        btn_a = ($urandom_range(0, 3) == 0);
        btn_b = ($urandom_range(0, 3) == 0);
        repeat (S) tick();
        btn_a = 1'b0; btn_b = 1'b0;
        chk("step_x", x_coord, (rcv != 0) ? i : FX - 1 - i);
        chk("step_y", y_coord, refl(y0, d, i));
      end
      chk("resp_state", game_state, (rcv != 0) ? 6 : 5);
      yexp = refl(y0, d, FX - 1);
      legs++;
      if (want < 0)
        act = (legs < 6 && $urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(2, 3));
      else
        act = (rcv == want) ? 1 : int'($urandom_range(2, 3));
      if (act == 3) begin
        repeat (RW - 1) tick();
        chk("window_open", game_state, (rcv != 0) ? 6 : 5);
        tick();
      end else begin
        dl = $urandom_range(1, RW - 1);
        repeat (dl - 1) begin
          if (rcv != 0) btn_a = ($urandom_range(0, 1) == 1);
          else          btn_b = ($urandom_range(0, 1) == 1);
          tick();
          btn_a = 1'b0; btn_b = 1'b0;
        end
        yin = (act == 1) ? yexp : int'((yexp + $urandom_range(1, 7)) % 8);
        d   = $urandom_range(0, 3);
        press(rcv, yin, d);
        if (act == 1) begin
          chk("hit_state", game_state, (rcv != 0) ? 4 : 3);
          chk("hit_x", x_coord, (rcv != 0) ? FX - 1 : 0);
          chk("hit_y", y_coord, yexp);
          y0  = yexp;
          rcv = 1 - rcv;
        end
      end
      if (act != 1) begin
        if (rcv != 0) m_sa++; else m_sb++;
        chk("goal_state", game_state, 7);
        chk("goal_score_a", score_a, m_sa);
        chk("goal_score_b", score_b, m_sb);
        repeat (GC - 1) tick();
        chk("goal_hold", game_state, 7);
        chk("goal_x", x_coord, (rcv != 0) ? FX - 1 : 0);
        tick();
        if (m_sa == WS || m_sb == WS) begin
          chk("end_state", game_state, 8);
          chk("end_winner", winner, (m_sa == WS) ? 1 : 2);
          over = 1'b1;
        end else begin
          chk("next_serve", game_state, (rcv != 0) ? 2 : 1);
          chk("next_serve_x", x_coord, (rcv != 0) ? FX - 1 : 0);
          chk("no_winner", winner, 0);
          server = rcv;
        end
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    btn_a = 1'b0; btn_b = 1'b0; dir_a = 2'b00; dir_b = 2'b00; y_a = '0; y_b = '0;
    tick();
    tick();
    chk("reset_state", game_state, 0);
    chk("reset_x", x_coord, 0);
    chk("reset_y", y_coord, 0);
    chk("reset_sa", score_a, 0);
    chk("reset_sb", score_b, 0);
    chk("reset_winner", winner, 0);
    rst = 1'b0;

    // ba bb da db ya yb n | state x y sa sb winner
    tbl[0]  = '{1,1,0,0,0,0,1, 1,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,2,0,1, 3,0,2,0,0,0};
    tbl[2]  = '{0,0,0,0,2,0,2, 3,1,2,0,0,0};
    tbl[3]  = '{0,0,0,0,2,0,2, 3,2,2,0,0,0};
    tbl[4]  = '{0,0,0,0,2,0,2, 3,3,2,0,0,0};
    tbl[5]  = '{0,0,0,0,2,0,2, 6,4,2,0,0,0};
    tbl[6]  = '{0,1,0,2,2,2,1, 4,4,2,0,0,0};
    tbl[7]  = '{0,0,0,2,2,2,2, 4,3,1,0,0,0};
    tbl[8]  = '{0,0,0,2,2,2,2, 4,2,0,0,0,0};
    tbl[9]  = '{0,0,0,2,2,2,2, 4,1,1,0,0,0};
    tbl[10] = '{0,0,0,2,2,2,2, 5,0,2,0,0,0};
    tbl[11] = '{0,0,0,2,2,2,3, 5,0,2,0,0,0};
    tbl[12] = '{0,0,0,2,2,2,1, 7,0,2,0,1,0};
    tbl[13] = '{0,0,0,2,2,2,2, 7,0,2,0,1,0};
    tbl[14] = '{0,0,0,2,2,2,1, 1,0,2,0,1,0};
    tbl[15] = '{0,1,0,2,2,2,1, 1,0,2,0,1,0};
    tbl[16] = '{1,0,1,2,3,2,1, 3,0,3,0,1,0};
    tbl[17] = '{0,0,1,2,3,2,2, 3,1,4,0,1,0};
    tbl[18] = '{0,0,1,2,3,2,2, 3,2,3,0,1,0};
    tbl[19] = '{0,0,1,2,3,2,2, 3,3,2,0,1,0};
    tbl[20] = '{0,0,1,2,3,2,2, 6,4,1,0,1,0};
    tbl[21] = '{1,0,1,2,3,2,1, 6,4,1,0,1,0};
    tbl[22] = '{0,1,1,2,3,2,1, 7,4,1,1,1,0};
    tbl[23] = '{0,0,1,2,3,2,3, 2,4,1,1,1,0};
    tbl[24] = '{0,1,1,0,3,7,1, 4,4,4,1,1,0};
    tbl[25] = '{0,0,1,0,3,7,8, 5,0,4,1,1,0};
    tbl[26] = '{0,0,1,0,3,7,4, 7,0,4,1,2,0};
    tbl[27] = '{0,0,1,0,3,7,3, 1,0,4,1,2,0};

    for (int k = 0; k < 28; k++) begin
      btn_a = (tbl[k].ba != 0);
      btn_b = (tbl[k].bb != 0);
      dir_a = 2'(tbl[k].da);
      dir_b = 2'(tbl[k].db);
      y_a   = CW'(tbl[k].ya);
      y_b   = CW'(tbl[k].yb);
      tick();
      btn_a = 1'b0; btn_b = 1'b0;
      repeat (tbl[k].n - 1) tick();
      chk($sformatf("vec%0d_state", k), game_state, tbl[k].st);
      chk($sformatf("vec%0d_x", k), x_coord, tbl[k].x);
      chk($sformatf("vec%0d_y", k), y_coord, tbl[k].y);
      chk($sformatf("vec%0d_sa", k), score_a, tbl[k].sa);
      chk($sformatf("vec%0d_sb", k), score_b, tbl[k].sb);
      chk($sformatf("vec%0d_winner", k), winner, tbl[k].w);
    end

    press(0, 1, 1);
    repeat (3) tick();
    chk("pre_rst_state", game_state, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_state", game_state, 0);
    chk("async_rst_x", x_coord, 0);
    chk("async_rst_y", y_coord, 0);
    chk("async_rst_sa", score_a, 0);
    chk("async_rst_sb", score_b, 0);
    chk("async_rst_winner", winner, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", game_state, 0);

    do_reset();
    press(0, 0, 0);
    server = 0;
    chk("me_serve", game_state, 1);
    repeat (3) play_point(0);
    chk("me_state", game_state, 8);
    chk("me_winner", winner, 1);
    chk("me_score_a", score_a, 3);
    chk("me_score_b", score_b, 0);
    for (int i = 0; i < 6; i++) begin
      btn_a = ($urandom_range(0, 1) == 1);
      btn_b = ($urandom_range(0, 1) == 1);
      y_a = CW'($urandom_range(0, 7));
      y_b = CW'($urandom_range(0, 7));
      tick();
    end
    btn_a = 1'b0; btn_b = 1'b0;
    chk("frozen_state", game_state, 8);
    chk("frozen_winner", winner, 1);
    chk("frozen_sa", score_a, 3);
    chk("frozen_sb", score_b, 0);
    chk("frozen_x", x_coord, FX - 1);

    for (int mt = 0; mt < 6; mt++) begin
      do_reset();
      chk("match_rst_state", game_state, 0);
      start_match();
      for (int pt = 0; pt < 2 * WS && !over; pt++) play_point(-1);
      chk("match_over", int'(over), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
